// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: sequencing controller for one radix-2 SDF FFT stage.
// Tracks frame position per lane, drives the butterfly commutator select,
// the twiddle address/enable and the output framing flags.
module fft_stage_ctrl #(
  parameter int D     = 24,
  parameter int N     = 32,
  parameter int FRAME = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sof,
  output logic                 in_ready,
  output logic                 ctrl_bf,
  output logic                 coeff_en,
  output logic [$clog2(N)-1:0] coeff_addr,
  output logic                 out_valid,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 err_sof,
  output logic [1:0]           state
);

  localparam int DW = (D > 1) ? $clog2(D) : 1;
  localparam int AW = $clog2(N);
  localparam int SW = $clog2(FRAME + 1);

  localparam logic [DW-1:0] dLast   = DW'(D - 1);
  localparam logic [AW-1:0] aLast   = AW'(N - 1);
  localparam logic [SW-1:0] sFill   = SW'(D);
  localparam logic [SW-1:0] sFrame  = SW'(FRAME);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } stateT;

  stateT         curState;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] flushCnt;
  logic [SW-1:0] smpCnt;
  logic [SW-1:0] smpNext;
  logic [AW-1:0] addrNext;
  logic          accept;
  logic          sofHit;
  logic          advance;

  // Status outputs are plain decodes of the state register.
  assign in_ready = (curState != FLUSH);
  assign coeff_en = (curState == RUN) || (curState == FLUSH);
  assign state    = curState;

  // Handshake qualification and the "advance" strobe that moves all counters.
  always_comb begin
    accept   = in_valid && in_ready;
    sofHit   = accept && in_sof;
    smpNext  = smpCnt + SW'(1);
    addrNext = (coeff_addr == aLast) ? '0 : coeff_addr + AW'(1);
    advance  = 1'b0;
    case (curState)
      IDLE:        advance = sofHit;
      FILL, RUN:   advance = accept;
      FLUSH:       advance = 1'b1;
      default:     advance = 1'b0;
    endcase
  end

  // Frame FSM with its counters and registered framing pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      curState   <= IDLE;
      dcnt       <= '0;
      flushCnt   <= '0;
      smpCnt     <= '0;
      coeff_addr <= '0;
      ctrl_bf    <= 1'b0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      err_sof   <= 1'b0;
      if (sofHit) begin
        // A start of frame always (re)starts the frame; mid-frame it is an error
        // and the abandoned frame never produces its end marker.
        err_sof    <= (curState == FILL) || (curState == RUN);
        curState   <= FILL;
        smpCnt     <= SW'(1);
        dcnt       <= DW'(1);
        ctrl_bf    <= 1'b0;
        coeff_addr <= '0;
        flushCnt   <= '0;
      end else if (advance) begin
        if (dcnt == dLast) begin
          dcnt    <= '0;
          ctrl_bf <= ~ctrl_bf;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
        case (curState)
          FILL: begin
            smpCnt <= smpNext;
            if (smpNext == sFill) begin
              curState   <= RUN;
              coeff_addr <= '0;
            end
          end
          RUN: begin
            smpCnt     <= smpNext;
            coeff_addr <= addrNext;
            out_valid  <= 1'b1;
            out_sof    <= (smpCnt == sFill);
            if (smpNext == sFrame) begin
              curState <= FLUSH;
              flushCnt <= '0;
            end
          end
          FLUSH: begin
            out_valid  <= 1'b1;
            coeff_addr <= addrNext;
            if (flushCnt == dLast) begin
              out_eof    <= 1'b1;
              curState   <= IDLE;
              flushCnt   <= '0;
              dcnt       <= '0;
              smpCnt     <= '0;
              coeff_addr <= '0;
              ctrl_bf    <= 1'b0;
            end else begin
              flushCnt <= flushCnt + DW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/fft_stage_ctrl.md
FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 The block SHALL have parameter D, default 24, meaning the butterfly delay-line depth and the ctrl_bf half-period in advances.
REQ-002 The block SHALL have parameter N, default 32, meaning the twiddle coefficient count; coeff_addr wraps modulo N.
REQ-003 The block SHALL have parameter FRAME, default 128, meaning accepted samples per lane per frame; legal only when FRAME >= 2*D and N >= 2.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, meaning the asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning a sample pair is present on both lanes.
REQ-007 The block SHALL have port in_sof, input, 1 bit, meaning the current sample is the first of a frame; it is qualified by in_valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a sample this cycle.
REQ-009 The block SHALL have port ctrl_bf, output, 1 bit, meaning the butterfly commutator select.
REQ-010 The block SHALL have port coeff_en, output, 1 bit, meaning the coefficient generator and multiplier enable.
REQ-011 The block SHALL have port coeff_addr, output, clog2(N) bits, meaning the twiddle index for the current advance.
REQ-012 The block SHALL have ports out_valid, out_sof, out_eof and err_sof, each output 1 bit, meaning output sample valid, first output, last output and protocol error pulse respectively.
REQ-013 The block SHALL have port state, output, 2 bits, meaning the FSM state for debug: IDLE=0, FILL=1, RUN=2, FLUSH=3.

Function
REQ-014 A sample SHALL be accepted when in_valid and in_ready are both 1; in_ready SHALL be 0 in FLUSH and 1 in every other state.
REQ-015 An advance SHALL occur on an accepted sample in FILL or RUN, on every cycle in FLUSH, and on an accepted sample with in_sof in IDLE.
REQ-016 In IDLE, an accepted sample with in_sof=0 SHALL be ignored; one with in_sof=1 SHALL start a frame: smp_cnt=1, dcnt=1, ctrl_bf=0, next state FILL.
REQ-017 dcnt SHALL count advances modulo D; on each wrap from D-1 to 0, ctrl_bf SHALL toggle.
REQ-018 FILL SHALL go to RUN on the advance that completes D accepted samples of the frame; on that transition coeff_addr SHALL load 0.
REQ-019 coeff_en SHALL be 1 exactly in RUN and FLUSH.
REQ-020 coeff_addr SHALL increment by one on each advance in RUN and FLUSH, wrapping N-1 to 0; it SHALL otherwise hold.
REQ-021 RUN SHALL go to FLUSH on the accepted sample that makes smp_cnt equal FRAME.
REQ-022 FLUSH SHALL last exactly D cycles and then enter IDLE, clearing dcnt, smp_cnt, coeff_addr and ctrl_bf.
REQ-023 out_valid SHALL be a registered copy, 1 cycle late, of each advance in RUN or FLUSH, giving exactly FRAME out_valid pulses per completed frame.
REQ-024 out_sof SHALL accompany the first out_valid of a frame; out_eof SHALL accompany the last out_valid, which is the final FLUSH advance.
REQ-025 An accepted in_sof in FILL or RUN SHALL pulse err_sof for 1 cycle, 1 cycle later, and SHALL restart the frame exactly as in REQ-016 (state FILL, coeff_en 0, coeff_addr 0), with no out_eof for the abandoned frame.
REQ-026 An in_sof presented during FLUSH SHALL NOT be accepted; upstream holds it and it is accepted in IDLE on the cycle after FLUSH ends.
REQ-027 Counters SHALL advance only on advances; in_valid gaps SHALL freeze dcnt, smp_cnt, coeff_addr and ctrl_bf.

Reset
REQ-028 When rst=0, the block SHALL asynchronously force state IDLE, clear dcnt, smp_cnt and coeff_addr to 0, drive ctrl_bf, coeff_en, out_valid, out_sof, out_eof and err_sof to 0, and drive in_ready to 1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no out_eof or err_sof; the first frame after release SHALL require in_sof.

Verification (D=4, N=8, FRAME=16)
REQ-030 Reset: assert rst=0 during RUN -> all outputs take the REQ-028 values in the same cycle; state=0.
REQ-031 Continuous frame: in_sof plus 16 contiguous valid cycles -> ctrl_bf per advance 0000 1111 0000 1111 0000; coeff_addr 0..7,0..7 over RUN+FLUSH; in_ready=0 for 4 cycles; 16 out_valid; out_sof on the first and out_eof on the 16th.
REQ-032 Gapped input: in_valid on alternate cycles -> ctrl_bf toggles every 4 accepted samples, not every 4 cycles; coeff_addr holds on gap cycles.
REQ-033 Mid-frame sof: new in_sof on the 10th sample -> err_sof=1 for 1 cycle, state=FILL, coeff_en=0, and the subsequent frame completes with 16 out_valid.
REQ-034 Back-to-back frames: in_sof held high during FLUSH -> in_ready=0 for 4 cycles; the sample is accepted in IDLE on the next cycle; no sample is lost or duplicated.
